prog_loader: RTL and testbench

- Parametrised program-memory loader for the small instruction core. Instructions arrive one word per strobe from an asynchronous pin-level `wr_strobe` and are stored sequentially from address 0.
- The core is held in reset via `master_clear` until the programmed length has been loaded, then released.
- Provides a read port for the core's fetch unit.
- Adds a configurable width, depth and program length, a synchronised strobe, reload-on-command and overflow flagging.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_strobe_sync.sv | 36 +++
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_pkg
// Shared definitions for the program-memory loader:
//   - FSM state encoding (LOAD / RUN)
//   - default instruction width and memory depth
//   - effective program length helper (0 or oversize length selects DEPTH)
// ---------------------------------------------------------------------------
package prog_pkg;

    localparam logic ST_LOAD = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int DEF_INSTR_WIDTH = 5;
    localparam int DEF_DEPTH       = 16;

    // A requested length of 0, or one larger than the memory, means
    // "fill the whole memory".
    function automatic int eff_len_f(input int len, input int depth);
        return ((len == 0) || (len > depth)) ? depth : len;
    endfunction

endpackage

// File: rtl/prog_loader_strobe_sync.sv
// ---------------------------------------------------------------------------
// strobe_sync
// Synchronises the asynchronous pin-level write strobe into the clk domain
// and produces a single-cycle pulse on each rising edge.
// Ports:
//   i_clk       system clock
//   i_clear     asynchronous active-high reset
//   i_strobe    asynchronous strobe input
//   o_wr_pulse  one-cycle pulse, SYNC_STAGES cycles after the strobe rises
// ---------------------------------------------------------------------------
module strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_clear,
    input  logic i_strobe,
    output logic o_wr_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // A strobe held high produces only one pulse.
    assign o_wr_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Loads a program into a small instruction memory, one word per external
// strobe, from address 0 upwards. The core is held in reset (master_clear=0)
// until the programmed length has been written, then released. A read port
// serves the core's fetch unit; addresses beyond the loaded length read as
// NOP_WORD.
//
// State table:
//   state | meaning
//   LOAD  | accepting words, core held in reset
//   RUN   | program complete, core released; strobes flag overflow
//
// Ports:
//   clk           system clock
//   clear         asynchronous active-high reset
//   wr_strobe     asynchronous load strobe (one word per rising edge)
//   instr_in      instruction word to store
//   load_start    one-cycle pulse: restart loading at address 0
//   load_len      program length sampled on load_start (0/oversize = DEPTH)
//   rd_addr       fetch address
//   rd_data       fetched instruction
//   master_clear  0 = core held in reset, 1 = core released
//   loading       high while in LOAD
//   word_count    words written in the current session
//   overflow      sticky flag: strobe received while in RUN
// ---------------------------------------------------------------------------
module prog_loader
    import prog_pkg::*;
#(
    parameter int                     INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int                     DEPTH       = DEF_DEPTH,
    parameter int                     ADDR_WIDTH  = $clog2(DEPTH),
    parameter int                     SYNC_STAGES = 2,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0,
    parameter bit                     REG_READ    = 1'b0
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   wr_strobe,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   load_start,
    input  logic [ADDR_WIDTH:0]    load_len,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [INSTR_WIDTH-1:0] rd_data,
    output logic                   master_clear,
    output logic                   loading,
    output logic [ADDR_WIDTH:0]    word_count,
    output logic                   overflow
);

    localparam int CW = ADDR_WIDTH + 1;

    logic                   r_state;
    logic [CW-1:0]          r_word_count;
    logic [CW-1:0]          r_eff_len;
    logic [CW-1:0]          r_loaded_len;
    logic                   r_master_clear;
    logic                   r_loading;
    logic                   r_overflow;
    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

    logic                   w_wr_pulse;
    logic                   w_we;
    logic                   w_last;
    logic                   w_rd_hit;
    logic [INSTR_WIDTH-1:0] w_rd_comb;

    strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .i_clk      (clk),
        .i_clear    (clear),
        .i_strobe   (wr_strobe),
        .o_wr_pulse (w_wr_pulse)
    );

    // load_start takes priority: a coincident strobe is dropped.
    assign w_we   = w_wr_pulse & ~load_start & (r_state == ST_LOAD);
    assign w_last = (r_word_count == r_eff_len - CW'(1));

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state        <= ST_LOAD;
            r_word_count   <= '0;
            r_eff_len      <= CW'(DEPTH);
            r_loaded_len   <= '0;
            r_master_clear <= 1'b0;
            r_loading      <= 1'b1;
            r_overflow     <= 1'b0;
        end else if (load_start) begin
            r_state        <= ST_LOAD;
            r_word_count   <= '0;
            r_eff_len      <= CW'(eff_len_f(int'(load_len), DEPTH));
            r_loaded_len   <= '0;
            r_master_clear <= 1'b0;
            r_loading      <= 1'b1;
            r_overflow     <= 1'b0;
        end else if (w_wr_pulse) begin
            if (r_state == ST_LOAD) begin
                r_word_count <= r_word_count + CW'(1);
                r_loaded_len <= r_word_count + CW'(1);
                if (w_last) begin
                    r_state        <= ST_RUN;
                    r_master_clear <= 1'b1;
                    r_loading      <= 1'b0;
                end
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end

    // The array is deliberately not reset; stale words are hidden by
    // r_loaded_len instead.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_word_count[ADDR_WIDTH-1:0]] <= instr_in;
        end
    end

    assign w_rd_hit  = ({1'b0, rd_addr} < r_loaded_len);
    assign w_rd_comb = w_rd_hit ? r_mem[rd_addr] : NOP_WORD;

    generate
        if (REG_READ) begin : g_reg_read
            logic [INSTR_WIDTH-1:0] r_rd_data;
            always_ff @(posedge clk or posedge clear) begin
                if (clear) begin
                    r_rd_data <= NOP_WORD;
                end else begin
                    r_rd_data <= w_rd_comb;
                end
            end
            assign rd_data = r_rd_data;
        end else begin : g_comb_read
            assign rd_data = w_rd_comb;
        end
    endgenerate

    assign master_clear = r_master_clear;
    assign loading      = r_loading;
    assign word_count   = r_word_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam logic [4:0] NOP_R = 5'h1E;

    logic       clk = 1'b0;
    logic       clear;
    logic       wr_strobe;
    logic [4:0] instr_in;
    logic       load_start;
    logic [4:0] load_len;
    logic [3:0] rd_addr;

    logic [4:0] rd_data,  rd_data_r;
    logic       mc,       mc_r;
    logic       loading,  loading_r;
    logic [4:0] wc,       wc_r;
    logic       ovf,      ovf_r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .clear(clear), .wr_strobe(wr_strobe), .instr_in(instr_in),
        .load_start(load_start), .load_len(load_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .master_clear(mc), .loading(loading),
        .word_count(wc), .overflow(ovf)
    );

    prog_loader #(.NOP_WORD(NOP_R), .REG_READ(1'b1)) dut_r (
        .clk(clk), .clear(clear), .wr_strobe(wr_strobe), .instr_in(instr_in),
        .load_start(load_start), .load_len(load_len), .rd_addr(rd_addr),
        .rd_data(rd_data_r), .master_clear(mc_r), .loading(loading_r),
        .word_count(wc_r), .overflow(ovf_r)
    );

    typedef struct {
        logic [3:0] addr;
        logic [4:0] exp;
        logic [4:0] exp_r;
    } rd_vec_t;

    rd_vec_t vecs[48];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_status(input string name, input logic e_mc, input logic [4:0] e_wc,
                              input logic e_ovf);
        chk({name, " master_clear"}, {31'd0, mc}, {31'd0, e_mc});
        chk({name, " loading"},      {31'd0, loading}, {31'd0, ~e_mc});
        chk({name, " word_count"},   {27'd0, wc}, {27'd0, e_wc});
        chk({name, " overflow"},     {31'd0, ovf}, {31'd0, e_ovf});
        chk({name, " master_clear_r"}, {31'd0, mc_r}, {31'd0, e_mc});
        chk({name, " word_count_r"},   {27'd0, wc_r}, {27'd0, e_wc});
    endtask

    // Apply table entries lo..hi; each read is held one cycle so the
    // registered-read instance has settled as well.
    task automatic run_vecs(input int lo, input int hi, input string name);
        for (int i = lo; i <= hi; i++) begin
            rd_addr = vecs[i].addr;
            @(posedge clk); #1;
            chk({name, " rd_data"},   {27'd0, rd_data},   {27'd0, vecs[i].exp});
            chk({name, " rd_data_r"}, {27'd0, rd_data_r}, {27'd0, vecs[i].exp_r});
        end
    endtask

    // Called at posedge+1; write lands on the 3rd edge after the rise.
    task automatic strobe(input logic [4:0] d);
        instr_in  = d;
        wr_strobe = 1'b1;
        repeat (4) @(posedge clk);
        #1 wr_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [4:0] len);
        load_len   = len;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [4:0] seg_b [4];
        seg_b[0] = 5'h1F; seg_b[1] = 5'h0A; seg_b[2] = 5'h03; seg_b[3] = 5'h11;
        // 0..15: full load of k; 16..31: 4-word program; 32..47: all NOP
        for (int k = 0; k < 16; k++) begin
            vecs[k]      = '{addr: 4'(k), exp: 5'(k), exp_r: 5'(k)};
            vecs[16 + k] = '{addr: 4'(k),
                             exp:   (k < 4) ? seg_b[k] : 5'h00,
                             exp_r: (k < 4) ? seg_b[k] : NOP_R};
            vecs[32 + k] = '{addr: 4'(k), exp: 5'h00, exp_r: NOP_R};
        end

        clear = 1'b1; wr_strobe = 1'b0; instr_in = '0;
        load_start = 1'b0; load_len = '0; rd_addr = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        chk_status("reset", 1'b0, 5'd0, 1'b0);
        chk("reset rd_data_r", {27'd0, rd_data_r}, {27'd0, NOP_R});
        clear = 1'b0;
        @(posedge clk); #1;

        // full 16-word load; timing checked on the last word
        for (int k = 0; k < 15; k++) strobe(5'(k));
        instr_in = 5'd15; wr_strobe = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_status("pre-last", 1'b0, 5'd15, 1'b0);
        @(posedge clk); #1;
        chk_status("post-last", 1'b1, 5'd16, 1'b0);
        @(posedge clk); #1 wr_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_vecs(0, 15, "full");

        // 4-word program, then an overflow strobe
        pulse_start(5'd4);
        chk_status("len4 start", 1'b0, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) strobe(seg_b[k]);
        chk_status("len4 3rd", 1'b0, 5'd3, 1'b0);
        strobe(seg_b[3]);
        chk_status("len4 done", 1'b1, 5'd4, 1'b0);
        run_vecs(16, 31, "len4");
        strobe(5'h07);
        chk_status("len4 ovf", 1'b1, 5'd4, 1'b1);
        run_vecs(16, 19, "len4 after ovf");

        // held-high strobe writes once, 3 cycles after the rise
        pulse_start(5'd0);
        chk_status("held start", 1'b0, 5'd0, 1'b0);
        instr_in = 5'h09; wr_strobe = 1'b1;
        @(posedge clk); #1 chk("held e1 wc", {27'd0, wc}, 32'd0);
        @(posedge clk); #1 chk("held e2 wc", {27'd0, wc}, 32'd0);
        @(posedge clk); #1 chk("held e3 wc", {27'd0, wc}, 32'd1);
        repeat (17) @(posedge clk);
        #1 chk("held e20 wc", {27'd0, wc}, 32'd1);
        wr_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_status("held end", 1'b0, 5'd1, 1'b0);
        rd_addr = 4'd0; #1 chk("held rd0", {27'd0, rd_data}, 32'h09);
        rd_addr = 4'd1; #1 chk("held rd1", {27'd0, rd_data}, 32'h00);

        // clear after 7 of 16 writes
        pulse_start(5'd0);
        for (int k = 0; k < 7; k++) strobe(5'(5'h15 + k));
        chk_status("mid-load", 1'b0, 5'd7, 1'b0);
        do_clear();
        chk_status("after clear", 1'b0, 5'd0, 1'b0);
        run_vecs(32, 47, "cleared");
        for (int k = 0; k < 16; k++) strobe(5'(k));
        chk_status("reload", 1'b1, 5'd16, 1'b0);
        run_vecs(0, 15, "reload");

        // overflow, then load_start coincident with wr_pulse in RUN
        strobe(5'h02);
        chk_status("run ovf", 1'b1, 5'd16, 1'b1);
        instr_in = 5'h1B; wr_strobe = 1'b1;
        repeat (2) @(posedge clk);
        #1 load_len = 5'd0; load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        chk_status("coincident", 1'b0, 5'd0, 1'b0);
        @(posedge clk); #1 wr_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_status("coincident end", 1'b0, 5'd0, 1'b0);
        rd_addr = 4'd0; #1 chk("coincident rd0", {27'd0, rd_data}, 32'h00);

        // load_len=0 means 16 words
        for (int k = 0; k < 15; k++) strobe(5'(k));
        chk_status("len0 15", 1'b0, 5'd15, 1'b0);
        strobe(5'd15);
        chk_status("len0 16", 1'b1, 5'd16, 1'b0);

        // registered read latency: 2 -> 5
        rd_addr = 4'd2;
        repeat (2) @(posedge clk);
        #1 rd_addr = 4'd5;
        #1;
        chk("lat old rd_data_r", {27'd0, rd_data_r}, 32'd2);
        chk("lat comb rd_data", {27'd0, rd_data}, 32'd5);
        @(posedge clk); #1;
        chk("lat new rd_data_r", {27'd0, rd_data_r}, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
